pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 8-bit pipelined RISC core. It drives the enable and flush inputs of every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and resolves competing hazards: data-memory wait, halt, taken branch and load-use. It also keeps a saturating stall-cycle counter and a sticky memory-timeout error. It sits beside the decode stage and takes its inputs from the ID, EX and MEM stages.

## Interface
- FLUSH_CYCLES, 2: cycles of IF/ID and ID/EX flush per taken branch, range 1..4.
- MEM_TIMEOUT, 16: maximum number of MEMWAIT cycles before an error is raised, range 1..255.
- CLK in 1: clock, rising edge.
- RST_n in 1: reset, asynchronous, active-low.
- ID_Rs1, ID_Rs2 in 2: source register addresses of the instruction in ID.
- ID_Use_Rs1, ID_Use_Rs2 in 1: the ID instruction actually reads that source.
- EX_MemRead in 1: the EX instruction is a load.
- EX_Rd in 2: destination register address in EX.
- EX_Br_Taken in 1: a branch in EX resolved taken this cycle.
- MEM_Req in 1: the MEM stage is accessing data memory.
- MEM_Ack in 1: the data memory completes the access this cycle.
- Halt_In in 1: a HALT instruction has reached WB.
- Resume in 1: single-cycle pulse that leaves HALT.
- PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En out 1: pipeline register enables.
- IFID_Flush, IDEX_Flush out 1: synchronous clear of the bubble register.
- Stall_Cnt out 8: number of cycles with PC_En=0, saturates at 255.
- Mem_Err out 1: sticky memory-timeout flag.
- State out 3: current FSM state, for debug.

## Operation
- States: RUN=0, FLUSH=1, MEMWAIT=2, HALT=3.
- Outputs are Mealy: they depend on the current state plus the current-cycle inputs.
- Default in RUN: all enables 1, both flushes 0.
- RUN priority, highest first:
  1. MEM_Req && !MEM_Ack: all enables 0 this cycle; next state MEMWAIT; wait counter set to 1.
  2. Halt_In: all enables 0; next state HALT.
  3. EX_Br_Taken: PC_En=1, IFID_Flush=1, IDEX_Flush=1. If FLUSH_CYCLES>1, next state FLUSH with flush counter = FLUSH_CYCLES-1; otherwise stay in RUN.
  4. Load-use: EX_MemRead && ((ID_Use_Rs1 && ID_Rs1==EX_Rd) || (ID_Use_Rs2 && ID_Rs2==EX_Rd)). Response: PC_En=0, IFID_En=0, IDEX_Flush=1, other enables 1. This is a single bubble and needs no state change.
- FLUSH:
  - IFID_Flush=1, IDEX_Flush=1, all enables 1.
  - Counter decrements each cycle; leave to RUN in the cycle the counter reaches 0.
  - EX_Br_Taken and load-use are ignored, because those instructions are squashed.
  - A memory stall (MEM_Req && !MEM_Ack) takes priority: go to MEMWAIT. The remaining flush count is discarded; the squashed ID/EX contents are already bubbles.
- MEMWAIT:
  - All enables 0 and flushes 0 while MEM_Ack=0; the wait counter increments.
  - MEM_Ack=1: all enables 1 in that cycle; next state RUN.
  - Timeout: wait counter reaches MEM_TIMEOUT with MEM_Ack still 0. Set Mem_Err=1; next state HALT.
- HALT:
  - All enables 0.
  - Resume=1 with Mem_Err=0: next state RUN.
  - Resume is ignored while Mem_Err=1. Only reset clears Mem_Err.
- Stall_Cnt increments on every clock edge where PC_En was 0, and holds at 255.

## Timing
- Reset (RST_n=0, asynchronous):
  - State=RUN, all counters 0, Mem_Err=0, Stall_Cnt=0.
  - All enables and flushes forced to 0 while reset is asserted.
  - First cycle after release: RUN defaults apply.
- Reset mid-FLUSH or mid-MEMWAIT aborts immediately; no pending flush or wait survives.
- Zero added latency: the enables and flushes respond in the same cycle as the causing input.
- Simultaneous cases:
  - Branch + load-use: branch wins; no PC hold.
  - MEM stall + branch: stall wins; the branch must be re-presented by EX after the stall, because EX/MEM is frozen.
  - MEM_Req with MEM_Ack in the same cycle: no stall.
- Halt_In is evaluated only in RUN.

## Structure
- Shared package core_ctrl_pkg holds:
  - the state encoding;
  - REG_AW=2;
  - constants for default FLUSH_CYCLES and MEM_TIMEOUT.
- One sub-module, hazard_detect: combinational load-use compare, output ld_use.
- The FSM, counters and output decode live in the top module.

## Test plan
- Load-use: EX_MemRead=1, EX_Rd=2, ID_Rs1=2, ID_Use_Rs1=1 for one cycle -> that cycle PC_En=0, IFID_En=0, IDEX_Flush=1; next cycle all enables 1; Stall_Cnt=1.
- Taken branch, FLUSH_CYCLES=2: EX_Br_Taken=1 in cycle 0 -> IFID_Flush=IDEX_Flush=1 in cycles 0-1, State=FLUSH in cycle 1, RUN in cycle 2.
- Memory wait: MEM_Req=1, MEM_Ack low for 3 cycles then high -> enables 0 for 3 cycles, 1 on the ack cycle; Stall_Cnt=3.
- Timeout, MEM_TIMEOUT=4: MEM_Req=1, MEM_Ack=0 held -> Mem_Err=1 and State=HALT. A later Resume pulse leaves State=HALT; RST_n low clears Mem_Err.
- Simultaneous branch + load-use -> PC_En=1, both flushes 1. MEM stall + branch -> all enables 0, State=MEMWAIT.
- Saturation: 300 held-halt cycles -> Stall_Cnt=255. Asynchronous reset mid-MEMWAIT -> State=0 and outputs 0 without a clock edge.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the pipeline control block.
// Holds the sequencer state encoding, the register-address width and the
// default flush length and memory-timeout limit.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_MEMWAIT = 3'd2,
    ST_HALT    = 3'd3
  } state_e;

  localparam int REG_AW           = 2;
  localparam int DEF_FLUSH_CYCLES = 2;
  localparam int DEF_MEM_TIMEOUT  = 16;

  localparam logic [7:0] STALL_MAX = 8'hFF;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector.
// Ports:
//   ex_memread_i       - instruction in EX is a load
//   ex_rd_i            - destination register of the EX instruction
//   id_rs1_i, id_rs2_i - source registers of the ID instruction
//   id_use_rs1_i/_rs2_i - the ID instruction really reads that source
//   ld_use_o           - ID needs the load result that is not yet available
module hazard_detect
  import core_ctrl_pkg::*;
(
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  output logic              ld_use_o
);

  assign ld_use_o = ex_memread_i &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 8-bit pipelined core.
// Drives the enables of PC, IF/ID, ID/EX, EX/MEM, MEM/WB and the flushes of
// IF/ID and ID/EX, resolving memory wait, halt, taken branch and load-use.
// Ports:
//   CLK, RST_n                  - clock, asynchronous active-low reset
//   ID_Rs1/Rs2, ID_Use_Rs1/Rs2  - ID source operands
//   EX_MemRead, EX_Rd           - EX load indication and destination
//   EX_Br_Taken                 - taken branch resolved in EX
//   MEM_Req, MEM_Ack            - data-memory handshake
//   Halt_In, Resume             - HALT reached WB / leave HALT pulse
//   *_En, *_Flush               - pipeline register controls (Mealy)
//   Stall_Cnt                   - saturating count of PC-hold cycles
//   Mem_Err                     - sticky memory-timeout flag
//   State                       - current sequencer state
module pipe_hazard_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [REG_AW-1:0] ID_Rs1,
  input  logic [REG_AW-1:0] ID_Rs2,
  input  logic              ID_Use_Rs1,
  input  logic              ID_Use_Rs2,
  input  logic              EX_MemRead,
  input  logic [REG_AW-1:0] EX_Rd,
  input  logic              EX_Br_Taken,
  input  logic              MEM_Req,
  input  logic              MEM_Ack,
  input  logic              Halt_In,
  input  logic              Resume,
  output logic              PC_En,
  output logic              IFID_En,
  output logic              IDEX_En,
  output logic              EXMEM_En,
  output logic              MEMWB_En,
  output logic              IFID_Flush,
  output logic              IDEX_Flush,
  output logic [7:0]        Stall_Cnt,
  output logic              Mem_Err,
  output logic [2:0]        State
);

  state_e      state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;

  logic ld_use;
  logic mem_stall;
  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_fl_c, idex_fl_c;

  hazard_detect u_hazard_detect (
    .ex_memread_i (EX_MemRead),
    .ex_rd_i      (EX_Rd),
    .id_rs1_i     (ID_Rs1),
    .id_rs2_i     (ID_Rs2),
    .id_use_rs1_i (ID_Use_Rs1),
    .id_use_rs2_i (ID_Use_Rs2),
    .ld_use_o     (ld_use)
  );

  // An access acknowledged in the same cycle it is requested is no stall.
  assign mem_stall = MEM_Req && !MEM_Ack;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    pc_en_c     = 1'b1;
    ifid_en_c   = 1'b1;
    idex_en_c   = 1'b1;
    exmem_en_c  = 1'b1;
    memwb_en_c  = 1'b1;
    ifid_fl_c   = 1'b0;
    idex_fl_c   = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
          state_d    = ST_MEMWAIT;
          wait_cnt_d = 8'd1;
        end else if (Halt_In) begin
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
          state_d = ST_HALT;
        end else if (EX_Br_Taken) begin
          ifid_fl_c = 1'b1;
          idex_fl_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = 3'(FLUSH_CYCLES - 1);
          end
        end else if (ld_use) begin
          // One bubble: hold PC and IF/ID, clear ID/EX.
          pc_en_c   = 1'b0;
          ifid_en_c = 1'b0;
          idex_fl_c = 1'b1;
        end
      end

      ST_FLUSH: begin
        if (mem_stall) begin
          // Remaining flush count is dropped; ID/EX already holds bubbles.
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
          state_d     = ST_MEMWAIT;
          wait_cnt_d  = 8'd1;
          flush_cnt_d = 3'd0;
        end else begin
          ifid_fl_c = 1'b1;
          idex_fl_c = 1'b1;
          if (flush_cnt_q <= 3'd1) begin
            flush_cnt_d = 3'd0;
            state_d     = ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
      end

      ST_MEMWAIT: begin
        if (MEM_Ack) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
          // The stall cycle spent in RUN already counted as wait cycle 1.
          if ((int'(wait_cnt_q) + 1) >= MEM_TIMEOUT) begin
            mem_err_d  = 1'b1;
            state_d    = ST_HALT;
            wait_cnt_d = 8'd0;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end

      ST_HALT: begin
        {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
        if (Resume && !mem_err_q) state_d = ST_RUN;
      end

      default: state_d = ST_RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (!pc_en_c && (stall_cnt_q != STALL_MAX)) stall_cnt_d = stall_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Controls are held inactive for as long as reset is asserted.
  assign PC_En      = RST_n & pc_en_c;
  assign IFID_En    = RST_n & ifid_en_c;
  assign IDEX_En    = RST_n & idex_en_c;
  assign EXMEM_En   = RST_n & exmem_en_c;
  assign MEMWB_En   = RST_n & memwb_en_c;
  assign IFID_Flush = RST_n & ifid_fl_c;
  assign IDEX_Flush = RST_n & idex_fl_c;
  assign Stall_Cnt  = stall_cnt_q;
  assign Mem_Err    = mem_err_q;
  assign State      = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       CLK;
  logic       RST_n;
  logic [1:0] ID_Rs1, ID_Rs2, EX_Rd;
  logic       ID_Use_Rs1, ID_Use_Rs2, EX_MemRead, EX_Br_Taken;
  logic       MEM_Req, MEM_Ack, Halt_In, Resume;
  logic       PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En;
  logic       IFID_Flush, IDEX_Flush, Mem_Err;
  logic [7:0] Stall_Cnt;
  logic [2:0] State;

  int checks = 0;
  int errors = 0;

  logic [4:0] en;
  logic [1:0] fl;
  assign en = {PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En};
  assign fl = {IFID_Flush, IDEX_Flush};

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_Use_Rs1(ID_Use_Rs1), .ID_Use_Rs2(ID_Use_Rs2),
    .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .EX_Br_Taken(EX_Br_Taken),
    .MEM_Req(MEM_Req), .MEM_Ack(MEM_Ack), .Halt_In(Halt_In), .Resume(Resume),
    .PC_En(PC_En), .IFID_En(IFID_En), .IDEX_En(IDEX_En), .EXMEM_En(EXMEM_En),
    .MEMWB_En(MEMWB_En), .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .Stall_Cnt(Stall_Cnt), .Mem_Err(Mem_Err), .State(State)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  task automatic clear_inputs();
    ID_Rs1 = 0; ID_Rs2 = 0; EX_Rd = 0;
    ID_Use_Rs1 = 0; ID_Use_Rs2 = 0; EX_MemRead = 0; EX_Br_Taken = 0;
    MEM_Req = 0; MEM_Ack = 0; Halt_In = 0; Resume = 0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge CLK); RST_n = 1'b0;
    @(posedge CLK); #1; RST_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST_n = 1'b0;
    EX_Br_Taken = 1'b1;
    #12;
    checks++; if (State !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", State); end
    checks++; if (en !== 5'b0) begin errors++; $display("FAIL reset_en got %b want 00000", en); end
    checks++; if (fl !== 2'b0) begin errors++; $display("FAIL reset_fl got %b want 00", fl); end
    checks++; if (Stall_Cnt !== 8'd0 || Mem_Err !== 1'b0) begin errors++; $display("FAIL reset_cnt stall %0d err %b want 0 0", Stall_Cnt, Mem_Err); end
    EX_Br_Taken = 1'b0;
    @(posedge CLK); #1; RST_n = 1'b1;
    @(negedge CLK);
    checks++; if (en !== 5'b11111 || fl !== 2'b00) begin errors++; $display("FAIL run_default en %b fl %b want 11111 00", en, fl); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    EX_MemRead = 1; EX_Rd = 2; ID_Rs1 = 2; ID_Use_Rs1 = 1;
    @(negedge CLK);
    checks++; if (en !== 5'b00111 || fl !== 2'b01) begin errors++; $display("FAIL ld_use_rs1 en %b fl %b want 00111 01", en, fl); end
    tick(); clear_inputs();
    @(negedge CLK);
    checks++; if (en !== 5'b11111 || fl !== 2'b00 || Stall_Cnt !== 8'd1) begin errors++; $display("FAIL ld_use_after en %b fl %b stall %0d want 11111 00 1", en, fl, Stall_Cnt); end
    tick();
    EX_MemRead = 1; EX_Rd = 1; ID_Rs2 = 1; ID_Use_Rs2 = 0; ID_Rs1 = 3; ID_Use_Rs1 = 1;
    @(negedge CLK);
    checks++; if (en !== 5'b11111 || fl !== 2'b00) begin errors++; $display("FAIL ld_use_unused en %b fl %b want 11111 00", en, fl); end
    ID_Use_Rs2 = 1;
    @(negedge CLK);
    checks++; if (en !== 5'b00111 || fl !== 2'b01) begin errors++; $display("FAIL ld_use_rs2 en %b fl %b want 00111 01", en, fl); end
    EX_MemRead = 0;
    @(negedge CLK);
    checks++; if (en !== 5'b11111) begin errors++; $display("FAIL no_load en %b want 11111", en); end
    tick(); clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    EX_Br_Taken = 1;
    @(negedge CLK);
    checks++; if (en !== 5'b11111 || fl !== 2'b11 || State !== 3'd0) begin errors++; $display("FAIL br_c0 en %b fl %b st %0d want 11111 11 0", en, fl, State); end
    tick();
    // Branch still high during FLUSH: must be ignored.
    @(negedge CLK);
    checks++; if (en !== 5'b11111 || fl !== 2'b11 || State !== 3'd1) begin errors++; $display("FAIL br_c1 en %b fl %b st %0d want 11111 11 1", en, fl, State); end
    tick(); EX_Br_Taken = 0;
    @(negedge CLK);
    checks++; if (fl !== 2'b00 || State !== 3'd0) begin errors++; $display("FAIL br_c2 fl %b st %0d want 00 0", fl, State); end
    tick();
    // Memory stall during FLUSH goes straight to MEMWAIT.
    EX_Br_Taken = 1; tick(); EX_Br_Taken = 0;
    MEM_Req = 1; MEM_Ack = 0;
    @(negedge CLK);
    checks++; if (en !== 5'b00000 || State !== 3'd1) begin errors++; $display("FAIL flush_stall en %b st %0d want 00000 1", en, State); end
    tick();
    @(negedge CLK);
    checks++; if (State !== 3'd2) begin errors++; $display("FAIL flush_to_memwait st %0d want 2", State); end
    MEM_Ack = 1; tick(); clear_inputs();
    @(negedge CLK);
    checks++; if (State !== 3'd0 || fl !== 2'b00) begin errors++; $display("FAIL flush_discard st %0d fl %b want 0 00", State, fl); end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    MEM_Req = 1; MEM_Ack = 0;
    @(negedge CLK);
    checks++; if (en !== 5'b00000 || State !== 3'd0) begin errors++; $display("FAIL mw_c0 en %b st %0d want 00000 0", en, State); end
    tick();
    @(negedge CLK);
    checks++; if (en !== 5'b00000 || State !== 3'd2) begin errors++; $display("FAIL mw_c1 en %b st %0d want 00000 2", en, State); end
    tick();
    @(negedge CLK);
    checks++; if (en !== 5'b00000 || State !== 3'd2) begin errors++; $display("FAIL mw_c2 en %b st %0d want 00000 2", en, State); end
    tick(); MEM_Ack = 1;
    @(negedge CLK);
    checks++; if (en !== 5'b11111 || State !== 3'd2) begin errors++; $display("FAIL mw_ack en %b st %0d want 11111 2", en, State); end
    tick(); clear_inputs();
    @(negedge CLK);
    checks++; if (State !== 3'd0 || Stall_Cnt !== 8'd3 || Mem_Err !== 1'b0) begin errors++; $display("FAIL mw_done st %0d stall %0d err %b want 0 3 0", State, Stall_Cnt, Mem_Err); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    MEM_Req = 1; MEM_Ack = 0;
    tick(); tick(); tick();
    @(negedge CLK);
    checks++; if (State !== 3'd2 || Mem_Err !== 1'b0) begin errors++; $display("FAIL to_pre st %0d err %b want 2 0", State, Mem_Err); end
    tick();
    @(negedge CLK);
    checks++; if (State !== 3'd3 || Mem_Err !== 1'b1 || en !== 5'b0) begin errors++; $display("FAIL to_halt st %0d err %b en %b want 3 1 00000", State, Mem_Err, en); end
    clear_inputs(); Resume = 1; tick(); Resume = 0;
    @(negedge CLK);
    checks++; if (State !== 3'd3 || Mem_Err !== 1'b1) begin errors++; $display("FAIL to_resume st %0d err %b want 3 1", State, Mem_Err); end
    RST_n = 0; #1;
    checks++; if (Mem_Err !== 1'b0 || State !== 3'd0) begin errors++; $display("FAIL to_reset err %b st %0d want 0 0", Mem_Err, State); end
    tick(); RST_n = 1;
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    EX_Br_Taken = 1; EX_MemRead = 1; EX_Rd = 1; ID_Rs1 = 1; ID_Use_Rs1 = 1;
    @(negedge CLK);
    checks++; if (en !== 5'b11111 || fl !== 2'b11) begin errors++; $display("FAIL br_ld en %b fl %b want 11111 11", en, fl); end
    tick(); clear_inputs(); tick();
    do_reset();
    MEM_Req = 1; MEM_Ack = 1;
    @(negedge CLK);
    checks++; if (en !== 5'b11111) begin errors++; $display("FAIL req_ack en %b want 11111", en); end
    tick(); MEM_Ack = 0; EX_Br_Taken = 1;
    @(negedge CLK);
    checks++; if (en !== 5'b00000 || fl !== 2'b00) begin errors++; $display("FAIL stall_br en %b fl %b want 00000 00", en, fl); end
    tick();
    @(negedge CLK);
    checks++; if (State !== 3'd2) begin errors++; $display("FAIL stall_br_st st %0d want 2", State); end
    // Asynchronous reset mid-MEMWAIT, away from any clock edge.
    RST_n = 0; #1;
    checks++; if (State !== 3'd0 || en !== 5'b0 || fl !== 2'b0 || Stall_Cnt !== 8'd0) begin errors++; $display("FAIL async_rst st %0d en %b fl %b stall %0d want 0 00000 00 0", State, en, fl, Stall_Cnt); end
    clear_inputs(); tick(); RST_n = 1;
    @(negedge CLK);
    checks++; if (State !== 3'd0 || en !== 5'b11111) begin errors++; $display("FAIL after_rst st %0d en %b want 0 11111", State, en); end
    tick();
  endtask

  task automatic test_halt_sat();
    do_reset();
    Halt_In = 1;
    @(negedge CLK);
    checks++; if (en !== 5'b00000) begin errors++; $display("FAIL halt_en en %b want 00000", en); end
    tick(); Halt_In = 0;
    @(negedge CLK);
    checks++; if (State !== 3'd3 || Stall_Cnt !== 8'd1) begin errors++; $display("FAIL halt_st st %0d stall %0d want 3 1", State, Stall_Cnt); end
    for (int i = 0; i < 300; i++) tick();
    @(negedge CLK);
    checks++; if (Stall_Cnt !== 8'd255) begin errors++; $display("FAIL stall_sat got %0d want 255", Stall_Cnt); end
    Resume = 1; tick(); Resume = 0;
    @(negedge CLK);
    checks++; if (State !== 3'd0 || en !== 5'b11111 || Stall_Cnt !== 8'd255) begin errors++; $display("FAIL halt_resume st %0d en %b stall %0d want 0 11111 255", State, en, Stall_Cnt); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_simultaneous();
    test_halt_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
